// File: rtl/lsu.sv
// ---------------------------------------------------------------------------
// lsu -- load/store unit between an in-order core and a single-port,
// ready/valid style data memory.
//
// Ports
//   clk_i, rst_i            clock, asynchronous active-high reset
//   core_req_i              core has a load/store this cycle
//   core_we_i               1 = store, 0 = load
//   core_size_i [2:0]       funct3 size code (B, H, W, BU, HU)
//   core_addr_i [31:0]      byte address
//   core_wd_i   [31:0]      store data, right-aligned
//   core_rd_o   [31:0]      extended load result, valid in RESP only
//   core_stall_o            core must hold its request
//   core_fault_o            misaligned / illegal-size request rejected
//   mem_req_o, mem_we_o     memory request / write enable
//   mem_be_o    [3:0]       byte enables
//   mem_addr_o  [31:0]      byte address (passed through)
//   mem_wd_o    [31:0]      lane-replicated write data
//   mem_rd_i    [31:0]      read data, valid the cycle after acceptance
//   mem_ready_i             memory accepts the request this cycle
//
// The core holds its request stable while stalled, so the memory-side
// outputs are driven straight from the core inputs; only the attributes
// needed to shape the read data are captured at acceptance.
// ---------------------------------------------------------------------------
module lsu (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        core_req_i,
   input  logic        core_we_i,
   input  logic [2:0]  core_size_i,
   input  logic [31:0] core_addr_i,
   input  logic [31:0] core_wd_i,
   output logic [31:0] core_rd_o,
   output logic        core_stall_o,
   output logic        core_fault_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wd_o,
   input  logic [31:0] mem_rd_i,
   input  logic        mem_ready_i
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   logic [1:0] state, state_nxt;
   logic [2:0] size_q;
   logic [1:0] off_q;
   logic       we_q;
   logic       ok;
   logic       accept;
   logic [7:0]  sel_b;
   logic [15:0] sel_h;

   // Legal size code with natural alignment.
   always_comb begin
      case (core_size_i)
         3'b000, 3'b100: ok = 1'b1;
         3'b001, 3'b101: ok = ~core_addr_i[0];
         3'b010:         ok = (core_addr_i[1:0] == 2'b00);
         default:        ok = 1'b0;
      endcase
   end

   // Outputs are forced quiet while reset is held, so an access caught in
   // REQ is dropped the moment rst_i rises rather than at the next edge.
   assign core_fault_o = ~rst_i & (state == IDLE) & core_req_i & ~ok;
   assign mem_req_o    = ~rst_i & (((state == IDLE) & core_req_i & ok) | (state == REQ));
   assign core_stall_o = ~rst_i & core_req_i & ~core_fault_o & (state != RESP);
   assign accept       = mem_req_o & mem_ready_i;

   assign mem_addr_o = core_addr_i;
   assign mem_we_o   = mem_req_o & core_we_i;

   always_comb begin
      mem_be_o = 4'b0000;
      mem_wd_o = core_wd_i;
      if (core_we_i) begin
         case (core_size_i[1:0])
            2'b00: begin
               mem_be_o = 4'b0001 << core_addr_i[1:0];
               mem_wd_o = {4{core_wd_i[7:0]}};
            end
            2'b01: begin
               mem_be_o = 4'b0011 << {core_addr_i[1], 1'b0};
               mem_wd_o = {2{core_wd_i[15:0]}};
            end
            default: mem_be_o = 4'b1111;
         endcase
      end else begin
         mem_be_o = 4'b1111;
      end
      if (!mem_req_o) mem_be_o = 4'b0000;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (mem_req_o) state_nxt = accept ? RESP : REQ;
         REQ:     if (accept)    state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state  <= IDLE;
         size_q <= 3'b000;
         off_q  <= 2'b00;
         we_q   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            size_q <= core_size_i;
            off_q  <= core_addr_i[1:0];
            we_q   <= core_we_i;
         end
      end
   end

   // Read-data shaping uses only the copies captured at acceptance, since
   // the core may already be changing its inputs during RESP.
   assign sel_b = mem_rd_i[{off_q, 3'b000} +: 8];
   assign sel_h = off_q[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];

   always_comb begin
      core_rd_o = 32'h0;
      if (state == RESP && !we_q) begin
         case (size_q)
            3'b000:  core_rd_o = {{24{sel_b[7]}}, sel_b};
            3'b100:  core_rd_o = {24'h0, sel_b};
            3'b001:  core_rd_o = {{16{sel_h[15]}}, sel_h};
            3'b101:  core_rd_o = {16'h0, sel_h};
            3'b010:  core_rd_o = mem_rd_i;
            default: core_rd_o = 32'h0;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu.sv
// ---------------------------------------------------------------------------
// tb_lsu -- self-checking bench for lsu. A byte-addressed memory model
// inside the bench answers the DUT; expected byte enables, write data and
// load results are derived from the byte-level meaning of each access.
// ---------------------------------------------------------------------------
module tb_lsu;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        core_req_i;
   logic        core_we_i;
   logic [2:0]  core_size_i;
   logic [31:0] core_addr_i;
   logic [31:0] core_wd_i;
   logic [31:0] core_rd_o;
   logic        core_stall_o;
   logic        core_fault_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wd_o;
   logic [31:0] mem_rd_i;
   logic        mem_ready_i;

   int tests = 0;
   int fails = 0;

   bit [7:0] mem [int unsigned];

   lsu dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .core_req_i(core_req_i), .core_we_i(core_we_i), .core_size_i(core_size_i),
      .core_addr_i(core_addr_i), .core_wd_i(core_wd_i), .core_rd_o(core_rd_o),
      .core_stall_o(core_stall_o), .core_fault_o(core_fault_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
      .mem_addr_o(mem_addr_o), .mem_wd_o(mem_wd_o),
      .mem_rd_i(mem_rd_i), .mem_ready_i(mem_ready_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit [7:0] rdb(input int unsigned a);
      if (mem.exists(a)) return mem[a];
      return 8'h00;
   endfunction

   function automatic logic [31:0] word_at(input int unsigned a);
      int unsigned b;
      b = a & ~32'd3;
      return {rdb(b + 3), rdb(b + 2), rdb(b + 1), rdb(b)};
   endfunction

   function automatic int nbytes(input logic [2:0] sz);
      case (sz[1:0])
         2'b00:   return 1;
         2'b01:   return 2;
         default: return 4;
      endcase
   endfunction

   function automatic logic [31:0] load_val(input logic [2:0] sz, input int unsigned a);
      longint v;
      int n;
      n = nbytes(sz);
      v = 0;
      for (int i = n - 1; i >= 0; i--) v = v * 256 + rdb(a + i);
      if (!sz[2] && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
      return v[31:0];
   endfunction

   // One full access from IDLE: request cycles, acceptance, then RESP check.
   task automatic access(input logic we, input logic [2:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, input int delay);
      int n;
      bit acc;
      logic [3:0] be_e;
      logic [31:0] wd_e, rd_e, wdv;
      int nb;
      nb = nbytes(sz);
      be_e = 4'b0000;
      if (we) for (int i = 0; i < nb; i++) be_e[(a[1:0] + i) % 4] = 1'b1;
      else be_e = 4'b1111;
      wdv = wd;
      wd_e = (nb == 1) ? {4{wdv[7:0]}} : (nb == 2) ? {2{wdv[15:0]}} : wdv;
      rd_e = we ? 32'h0 : load_val(sz, a);

      core_req_i = 1'b1; core_we_i = we; core_size_i = sz;
      core_addr_i = a; core_wd_i = wd;
      mem_ready_i = (delay == 0);
      n = 0; acc = 0;
      while (!acc && n < 50) begin
         @(negedge clk_i);
         chk("req.mem_req", mem_req_o, 1);
         chk("req.stall", core_stall_o, 1);
         chk("req.fault", core_fault_o, 0);
         chk("req.we", mem_we_o, we);
         chk("req.be", mem_be_o, be_e);
         chk("req.addr", mem_addr_o, a);
         chk("req.rd", core_rd_o, 0);
         if (we) chk("req.wd", mem_wd_o, wd_e);
         acc = mem_ready_i;
         @(posedge clk_i); #1;
         n++;
         if (acc) begin
            if (we) for (int i = 0; i < nb; i++) mem[a + i] = wd_e[8 * ((a[1:0] + i) % 4) +: 8];
            mem_rd_i = word_at(a);
         end
         mem_ready_i = (n >= delay);
      end
      chk("stall_cycles", n, delay + 1);
      @(negedge clk_i);
      chk("resp.stall", core_stall_o, 0);
      chk("resp.mem_req", mem_req_o, 0);
      chk("resp.rd", core_rd_o, rd_e);
      @(posedge clk_i); #1;
      core_req_i = 1'b0;
      mem_ready_i = 1'b1;
      mem_rd_i = $urandom;
   endtask

   task automatic fault(input logic [2:0] sz, input logic [31:0] a);
      core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = sz; core_addr_i = a;
      @(negedge clk_i);
      chk("flt.fault", core_fault_o, 1);
      chk("flt.stall", core_stall_o, 0);
      chk("flt.mem_req", mem_req_o, 0);
      chk("flt.be", mem_be_o, 0);
      @(posedge clk_i); #1;
      core_req_i = 1'b0;
      @(negedge clk_i);
      chk("flt.idle_req", mem_req_o, 0);
      chk("flt.idle_fault", core_fault_o, 0);
      @(posedge clk_i); #1;
   endtask

   initial begin
      rst_i = 1'b1;
      core_req_i = 1'b1; core_we_i = 1'b1; core_size_i = 3'b010;
      core_addr_i = 32'h10; core_wd_i = 32'h0;
      mem_rd_i = 32'hFFFF_FFFF; mem_ready_i = 1'b1;
      @(negedge clk_i);
      chk("rst.mem_req", mem_req_o, 0);
      chk("rst.we", mem_we_o, 0);
      chk("rst.be", mem_be_o, 0);
      chk("rst.stall", core_stall_o, 0);
      chk("rst.fault", core_fault_o, 0);
      chk("rst.rd", core_rd_o, 0);
      core_req_i = 1'b0;
      @(posedge clk_i); #1;
      rst_i = 1'b0;

      // Word store / load round trip.
      access(1'b1, 3'b010, 32'h10, 32'hCAFEBABE, 0);
      access(1'b0, 3'b010, 32'h10, 32'h0, 0);
      chk("sw_lw", word_at(32'h10), 32'hCAFEBABE);
      // Byte store to the top lane, then signed and unsigned byte loads.
      access(1'b1, 3'b000, 32'h13, 32'h000000A5, 0);
      access(1'b0, 3'b000, 32'h13, 32'h0, 0);
      access(1'b0, 3'b100, 32'h13, 32'h0, 0);
      // Misaligned and illegal-size requests.
      fault(3'b001, 32'h21);
      fault(3'b010, 32'h22);
      fault(3'b011, 32'h20);
      // Unsigned halfword with memory back-pressure.
      mem[32'h12] = 8'h01; mem[32'h13] = 8'h80;
      access(1'b0, 3'b101, 32'h12, 32'h0, 3);
      chk("lhu_val", load_val(3'b101, 32'h12), 32'h00008001);
      // Reset while the access waits in REQ.
      core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = 3'b010; core_addr_i = 32'h30;
      mem_ready_i = 1'b0;
      @(negedge clk_i);
      chk("rreq.mem_req", mem_req_o, 1);
      @(posedge clk_i); #2;
      rst_i = 1'b1;
      #1;
      chk("rreq.drop", mem_req_o, 0);
      chk("rreq.stall", core_stall_o, 0);
      core_req_i = 1'b0;
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      mem_ready_i = 1'b1;
      mem[32'h30] = 8'h44; mem[32'h31] = 8'h33; mem[32'h32] = 8'h22; mem[32'h33] = 8'h11;
      access(1'b0, 3'b010, 32'h30, 32'h0, 0);
      // Far address returning a sentinel word.
      mem[32'h4000] = 8'hEF; mem[32'h4001] = 8'hBE; mem[32'h4002] = 8'hAD; mem[32'h4003] = 8'hDE;
      access(1'b0, 3'b010, 32'h4000, 32'h0, 0);

      // Randomized mix against the byte-level model.
      for (int i = 0; i < 64; i++) mem[32'h100 + i] = 8'($urandom);
      for (int it = 0; it < 80; it++) begin
         logic [2:0] sz;
         logic [31:0] a;
         int k;
         k = $urandom_range(0, 5);
         case (k)
            0: sz = 3'b000; 1: sz = 3'b001; 2: sz = 3'b010;
            3: sz = 3'b100; 4: sz = 3'b101; default: sz = 3'($urandom_range(6, 7));
         endcase
         if (k == 5 && $urandom_range(0, 1) == 1) sz = 3'b011;
         a = 32'h100 + $urandom_range(0, 60);
         if (k == 5 || (nbytes(sz) == 2 && a[0]) || (nbytes(sz) == 4 && a[1:0] != 0))
            fault(sz, a);
         else
            access((sz[2] ? 1'b0 : 1'($urandom_range(0, 1))), sz, a, $urandom, $urandom_range(0, 2));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
